ecc_26_wr_enc: RTL and testbench

- Write-side SECDED encoder for the 26-bit ECC FIFO path. It is the producer of the 26+6 codewords that the read-side checker corrects.
- Accepts 26-bit data on a valid/ready stream and computes the 6 parity bits. Drives the codeword into FIFO storage through a registered, full-throughput skid stage.
- Provides programmable single/double bit error injection so the read-side corrector can be exercised in silicon. Counts accepted words and injected errors.

---
 rtl/ecc26_pkg.sv | 34 +++
 rtl/ecc_26_enc.sv | 14 +
 rtl/ecc_26_wr_enc.sv | 166 ++++++++++++++++
 tb/tb_ecc_26_wr_enc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc26_pkg.sv
// Shared constants and types for the 26-bit SECDED FIFO path (write encoder and read checker).
package ecc26_pkg;

    localparam int DATA_WIDTH   = 26;
    localparam int PARITY_WIDTH = 6;
    localparam int CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH;

    // H-matrix data columns d0..d25; parity bits own the weight-1 columns.
    localparam logic [PARITY_WIDTH-1:0] ECC_COLS [0:DATA_WIDTH-1] = '{
        6'h23, 6'h25, 6'h26, 6'h07, 6'h29, 6'h2A, 6'h0B, 6'h2C, 6'h0D, 6'h0E,
        6'h2F, 6'h31, 6'h32, 6'h13, 6'h34, 6'h15, 6'h16, 6'h37, 6'h38, 6'h19,
        6'h1A, 6'h3B, 6'h1C, 6'h3D, 6'h3E, 6'h1F
    };

    typedef enum logic [1:0] {
        INJ_NONE   = 2'd0,
        INJ_SINGLE = 2'd1,
        INJ_DOUBLE = 2'd2
    } inj_mode_e;

    function automatic logic [PARITY_WIDTH-1:0] ecc_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        p = {PARITY_WIDTH{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (d[i]) begin
                p = p ^ ECC_COLS[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_26_enc.sv
// Combinational SECDED parity generator for 26 data bits; shared with the read-side checker.
module ecc_26_enc
    import ecc26_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [PARITY_WIDTH-1:0] parity_o
);

    // Parity is a pure function of the data word.
    always_comb begin
        parity_o = ecc_parity(data_i);
    end

endmodule

// File: rtl/ecc_26_wr_enc.sv
// Write-side SECDED encoder: parity generation, error injection, registered skid stage, counters.
module ecc_26_wr_enc
    import ecc26_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [PARITY_WIDTH-1:0] m_parity,
    input  logic                    inj_arm,
    input  logic [1:0]              inj_mode,
    input  logic                    inj_once,
    input  logic [4:0]              inj_pos0,
    input  logic [4:0]              inj_pos1,
    input  logic                    inj_disarm,
    output logic                    inj_armed,
    output logic                    inj_done,
    output logic [CNT_WIDTH-1:0]    wr_cnt,
    output logic [CNT_WIDTH-1:0]    inj_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [PARITY_WIDTH-1:0] parity_s;
    logic [CW_WIDTH-1:0]     mask_s, cw_s;
    logic                    in_fire_s, out_fire_s;

    logic                    s_ready_q, s_ready_d;
    logic                    m_valid_q, m_valid_d;
    logic [CW_WIDTH-1:0]     m_cw_q, m_cw_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [CW_WIDTH-1:0]     skid_cw_q, skid_cw_d;

    logic                    armed_q, armed_d;
    logic                    done_q, done_d;
    logic                    once_q, once_d;
    logic [1:0]              mode_q, mode_d;
    logic [4:0]              pos0_q, pos0_d, pos1_q, pos1_d;
    logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d, inj_cnt_q, inj_cnt_d;

    ecc_26_enc u_enc (
        .data_i   (s_data),
        .parity_o (parity_s)
    );

    assign in_fire_s  = s_valid & s_ready_q;
    assign out_fire_s = m_valid_q & m_ready;

    // Flip mask from the armed settings; a same-cycle arm only affects later words.
    always_comb begin
        mask_s = {CW_WIDTH{1'b0}};
        if (armed_q) begin
            case (mode_q)
                INJ_SINGLE: mask_s = 32'd1 << pos0_q;
                INJ_DOUBLE: mask_s = (32'd1 << pos0_q) | (32'd1 << pos1_q);
                default:    mask_s = {CW_WIDTH{1'b0}};
            endcase
        end else begin
            mask_s = {CW_WIDTH{1'b0}};
        end
        cw_s = {parity_s, s_data} ^ mask_s;
    end

    // Skid stage: main register feeds the FIFO, skid catches the word accepted during a stall.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_cw_d       = m_cw_q;
        skid_valid_d = skid_valid_q;
        skid_cw_d    = skid_cw_q;
        if (!m_valid_q || out_fire_s) begin
            if (skid_valid_q) begin
                m_valid_d    = 1'b1;
                m_cw_d       = skid_cw_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                m_valid_d = 1'b1;
                m_cw_d    = cw_s;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_fire_s) begin
            skid_valid_d = 1'b1;
            skid_cw_d    = cw_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        s_ready_d = !skid_valid_d;
    end

    // Injection control (disarm beats arm) and saturating counters.
    always_comb begin
        mode_d = mode_q;
        once_d = once_q;
        pos0_d = pos0_q;
        pos1_d = pos1_q;
        done_d = in_fire_s & armed_q & once_q;
        if (inj_disarm) begin
            armed_d = 1'b0;
        end else if (inj_arm) begin
            mode_d  = inj_mode;
            once_d  = inj_once;
            pos0_d  = inj_pos0;
            pos1_d  = inj_pos1;
            armed_d = (inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE);
        end else if (done_d) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
        wr_cnt_d  = in_fire_s ? sat_inc(wr_cnt_q) : wr_cnt_q;
        inj_cnt_d = (in_fire_s && (mask_s != {CW_WIDTH{1'b0}})) ? sat_inc(inj_cnt_q) : inj_cnt_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_cw_q       <= {CW_WIDTH{1'b0}};
            skid_valid_q <= 1'b0;
            skid_cw_q    <= {CW_WIDTH{1'b0}};
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            once_q       <= 1'b0;
            mode_q       <= 2'd0;
            pos0_q       <= 5'd0;
            pos1_q       <= 5'd0;
            wr_cnt_q     <= {CNT_WIDTH{1'b0}};
            inj_cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_cw_q       <= m_cw_d;
            skid_valid_q <= skid_valid_d;
            skid_cw_q    <= skid_cw_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            once_q       <= once_d;
            mode_q       <= mode_d;
            pos0_q       <= pos0_d;
            pos1_q       <= pos1_d;
            wr_cnt_q     <= wr_cnt_d;
            inj_cnt_q    <= inj_cnt_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_cw_q[DATA_WIDTH-1:0];
    assign m_parity  = m_cw_q[CW_WIDTH-1:DATA_WIDTH];
    assign inj_armed = armed_q;
    assign inj_done  = done_q;
    assign wr_cnt    = wr_cnt_q;
    assign inj_cnt   = inj_cnt_q;

endmodule

// File: tb/tb_ecc_26_wr_enc.sv
// Directed bench for ecc_26_wr_enc: encode table, injection sequences, stalled stream, async reset.
module tb_ecc_26_wr_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [25:0] s_data, m_data;
    logic [5:0]  m_parity;
    logic        inj_arm, inj_once, inj_disarm, inj_armed, inj_done;
    logic [1:0]  inj_mode;
    logic [4:0]  inj_pos0, inj_pos1;
    logic [15:0] wr_cnt, inj_cnt;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_inj = 0;

    localparam logic [5:0] TB_COLS [0:25] = '{
        6'h23, 6'h25, 6'h26, 6'h07, 6'h29, 6'h2A, 6'h0B, 6'h2C, 6'h0D, 6'h0E,
        6'h2F, 6'h31, 6'h32, 6'h13, 6'h34, 6'h15, 6'h16, 6'h37, 6'h38, 6'h19,
        6'h1A, 6'h3B, 6'h1C, 6'h3D, 6'h3E, 6'h1F
    };

    typedef struct {
        logic [25:0] d;
        logic [5:0]  p;
    } vec_t;

    vec_t vecs [7];

    ecc_26_wr_enc #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_parity(m_parity),
        .inj_arm(inj_arm), .inj_mode(inj_mode), .inj_once(inj_once),
        .inj_pos0(inj_pos0), .inj_pos1(inj_pos1), .inj_disarm(inj_disarm),
        .inj_armed(inj_armed), .inj_done(inj_done),
        .wr_cnt(wr_cnt), .inj_cnt(inj_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_par(input logic [25:0] d);
        logic [5:0] p = 6'd0;
        for (int i = 0; i < 26; i++) if (d[i]) p = p ^ TB_COLS[i];
        return p;
    endfunction

    function automatic logic [25:0] word(input int i);
        logic [31:0] w = 32'h0155_AAA3 + 32'(i) * 32'h0012_3457;
        return w[25:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One accepted word; returns at the negedge where it sits in the output register.
    task automatic push(input logic [25:0] d, input bit injected);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        exp_wr++;
        if (injected) exp_inj++;
    endtask

    task automatic arm(input logic [1:0] mode, input logic once, input logic [4:0] p0, input logic [4:0] p1);
        @(negedge clk);
        inj_arm  = 1'b1;
        inj_mode = mode;
        inj_once = once;
        inj_pos0 = p0;
        inj_pos1 = p1;
        @(negedge clk);
        inj_arm  = 1'b0;
        inj_mode = 2'd0;
        inj_pos0 = 5'd7;
        inj_pos1 = 5'd9;
    endtask

    task automatic disarm();
        @(negedge clk);
        inj_disarm = 1'b1;
        @(negedge clk);
        inj_disarm = 1'b0;
    endtask

    initial begin
        int snd, rcv;
        bit stall_prev;
        logic [25:0] held_d;
        logic [5:0]  held_p;

        vecs[0] = '{26'h0000001, 6'h23};
        vecs[1] = '{26'h3FFFFFF, 6'h3F};
        vecs[2] = '{26'h0000002, 6'h25};
        vecs[3] = '{26'h0000000, 6'h00};
        vecs[4] = '{26'h2000000, 6'h1F};
        vecs[5] = '{26'h0000003, 6'h06};
        vecs[6] = '{26'h0000030, 6'h03};

        rst_n = 1'b0; s_valid = 1'b0; s_data = 26'd0; m_ready = 1'b1;
        inj_arm = 1'b0; inj_mode = 2'd0; inj_once = 1'b0; inj_pos0 = 5'd0; inj_pos1 = 5'd0;
        inj_disarm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst s_ready", 32'(s_ready), 32'd1);
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst m_data", 32'(m_data), 32'd0);
        check("rst m_parity", 32'(m_parity), 32'd0);
        check("rst inj_armed", 32'(inj_armed), 32'd0);
        check("rst inj_done", 32'(inj_done), 32'd0);
        check("rst wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst inj_cnt", 32'(inj_cnt), 32'd0);

        for (int i = 0; i < 7; i++) begin
            push(vecs[i].d, 1'b0);
            check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'd1);
            check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].d));
            check($sformatf("vec%0d m_parity", i), 32'(m_parity), 32'(vecs[i].p));
        end
        check("table wr_cnt", 32'(wr_cnt), 32'(exp_wr));

        // Single-bit one-shot at data bit 3; later input changes must not matter.
        arm(2'd1, 1'b1, 5'd3, 5'd0);
        check("A armed", 32'(inj_armed), 32'd1);
        push(26'd0, 1'b1);
        check("A m_data", 32'(m_data), 32'h8);
        check("A m_parity", 32'(m_parity), 32'h0);
        check("A inj_done", 32'(inj_done), 32'd1);
        check("A disarmed", 32'(inj_armed), 32'd0);
        @(negedge clk);
        check("A done pulse ends", 32'(inj_done), 32'd0);
        check("A inj_cnt", 32'(inj_cnt), 32'(exp_inj));

        // Continuous double-bit on d0,d1.
        arm(2'd2, 1'b0, 5'd0, 5'd1);
        for (int k = 0; k < 2; k++) begin
            push(26'd0, 1'b1);
            check($sformatf("B%0d m_data", k), 32'(m_data), 32'h3);
            check($sformatf("B%0d m_parity", k), 32'(m_parity), 32'h0);
            check($sformatf("B%0d inj_done", k), 32'(inj_done), 32'd0);
        end
        check("B still armed", 32'(inj_armed), 32'd1);
        check("B inj_cnt", 32'(inj_cnt), 32'(exp_inj));
        disarm();
        check("B disarm", 32'(inj_armed), 32'd0);
        push(26'd0, 1'b0);
        check("B clean after disarm", 32'(m_data), 32'h0);

        // Parity-bit flip at codeword index 26.
        arm(2'd1, 1'b0, 5'd26, 5'd0);
        push(26'd0, 1'b1);
        check("C m_data", 32'(m_data), 32'h0);
        check("C m_parity", 32'(m_parity), 32'h01);
        disarm();

        // Double mode with equal positions flips one bit.
        arm(2'd2, 1'b1, 5'd5, 5'd5);
        push(26'd0, 1'b1);
        check("D m_data", 32'(m_data), 32'h20);
        check("D m_parity", 32'(m_parity), 32'h0);

        arm(2'd3, 1'b0, 5'd1, 5'd0);
        check("mode3 not armed", 32'(inj_armed), 32'd0);
        @(negedge clk);
        inj_arm = 1'b1; inj_disarm = 1'b1; inj_mode = 2'd1;
        @(negedge clk);
        inj_arm = 1'b0; inj_disarm = 1'b0; inj_mode = 2'd0;
        check("disarm wins", 32'(inj_armed), 32'd0);

        // Arm and accept in the same cycle: that word stays clean.
        @(negedge clk);
        inj_arm = 1'b1; inj_mode = 2'd1; inj_once = 1'b1; inj_pos0 = 5'd0;
        s_valid = 1'b1; s_data = 26'd0;
        @(negedge clk);
        inj_arm = 1'b0; s_valid = 1'b0; exp_wr++;
        check("E same-cycle clean", 32'(m_data), 32'h0);
        check("E armed", 32'(inj_armed), 32'd1);
        check("E no done", 32'(inj_done), 32'd0);
        push(26'd0, 1'b1);
        check("E next injected", 32'(m_data), 32'h1);
        check("E done", 32'(inj_done), 32'd1);
        check("E wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("E inj_cnt", 32'(inj_cnt), 32'(exp_inj));

        // Stalled stream: m_ready pattern 1,0,0,1.
        @(negedge clk);
        snd = 0; rcv = 0; stall_prev = 1'b0; held_d = 26'd0; held_p = 6'd0;
        for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
            if (cyc != 0) @(negedge clk);
            check("S m_valid", 32'(m_valid), 32'((snd - rcv) > 0));
            check("S s_ready", 32'(s_ready), 32'((snd - rcv) < 2));
            if (stall_prev) begin
                check("S hold data", 32'(m_data), 32'(held_d));
                check("S hold parity", 32'(m_parity), 32'(held_p));
            end
            m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            s_valid = (snd < 8);
            s_data  = word(snd);
            if (m_valid && m_ready) begin
                check($sformatf("S word%0d data", rcv), 32'(m_data), 32'(word(rcv)));
                check($sformatf("S word%0d parity", rcv), 32'(m_parity), 32'(ref_par(word(rcv))));
                rcv++;
            end
            if (s_valid && s_ready) snd++;
            stall_prev = m_valid && !m_ready;
            held_d = m_data;
            held_p = m_parity;
        end
        check("S delivered", 32'(rcv), 32'd8);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        exp_wr += 8;
        @(negedge clk);
        check("S wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("S drained", 32'(m_valid), 32'd0);

        // Two words in flight plus armed injection, then async reset mid-cycle.
        arm(2'd1, 1'b0, 5'd2, 5'd0);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 26'h1;
        @(negedge clk);
        s_data = 26'h2;
        @(negedge clk);
        s_valid = 1'b0;
        check("R pre skid full", 32'(s_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("R m_valid", 32'(m_valid), 32'd0);
        check("R s_ready", 32'(s_ready), 32'd1);
        check("R inj_armed", 32'(inj_armed), 32'd0);
        check("R wr_cnt", 32'(wr_cnt), 32'd0);
        check("R inj_cnt", 32'(inj_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("R no stale word", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
